// File: rtl/ed_threshold_writer.sv
// ed_threshold_writer: averages 2^LOG2_AVG squared-magnitude samples, scales the mean and writes threshold and window size over the settings bus
module ed_threshold_writer #(
  parameter int TH_ADDR = 1,
  parameter int WS_ADDR = 3,
  parameter int LOG2_AVG = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] xk_sq_m,
  input  logic        dv_sq_m,
  input  logic        start,
  input  logic [7:0]  scale_q4,
  input  logic [9:0]  window_size_in,
  output logic        set_stb,
  output logic [7:0]  set_addr,
  output logic [31:0] set_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] th_out
);
  localparam int AW = 32 + LOG2_AVG;
  typedef enum logic [2:0] {IDLE, ACCUM, MEAN, SCALE, WR_TH, GAP, WR_WS, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [LOG2_AVG-1:0] cnt_q, cnt_d;
  logic [31:0] mean_q, mean_d, th_q, th_d, set_data_q, set_data_d, th_out_q, th_out_d;
  logic [7:0] set_addr_q, set_addr_d;
  logic set_stb_q, set_stb_d, busy_q, busy_d, done_q, done_d;
  logic [39:0] prod;
  logic [9:0] ws;
  assign prod = 40'(mean_q) * 40'(scale_q4);
  assign ws = (window_size_in == 10'd0) ? 10'd1 : window_size_in;
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    mean_d = mean_q;
    th_d = th_q;
    set_stb_d = 1'b0;
    set_addr_d = set_addr_q;
    set_data_d = set_data_q;
    busy_d = busy_q;
    done_d = 1'b0;
    th_out_d = th_out_q;
    case (state_q)
      IDLE: begin
        busy_d = start && !busy_q;
        if (start && !busy_q) begin
          state_d = ACCUM;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      ACCUM: if (dv_sq_m) begin
        acc_d = acc_q + AW'(xk_sq_m);
        cnt_d = cnt_q + LOG2_AVG'(1);
        state_d = (&cnt_q) ? MEAN : ACCUM;
      end
      MEAN: begin
        mean_d = acc_q[LOG2_AVG +: 32];
        state_d = SCALE;
      end
      SCALE: begin
        th_d = (|prod[39:36]) ? 32'hFFFF_FFFF : prod[35:4];
        state_d = WR_TH;
      end
      WR_TH: begin
        set_stb_d = 1'b1;
        set_addr_d = 8'(TH_ADDR);
        set_data_d = th_q;
        th_out_d = th_q;
        state_d = GAP;
      end
      GAP: state_d = WR_WS;
      WR_WS: begin
        set_stb_d = 1'b1;
        set_addr_d = 8'(WS_ADDR);
        set_data_d = {22'b0, ws};
        state_d = DONE;
      end
      DONE: begin
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      mean_q <= '0;
      th_q <= '0;
      set_stb_q <= 1'b0;
      set_addr_q <= '0;
      set_data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      th_out_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      mean_q <= mean_d;
      th_q <= th_d;
      set_stb_q <= set_stb_d;
      set_addr_q <= set_addr_d;
      set_data_q <= set_data_d;
      busy_q <= busy_d;
      done_q <= done_d;
      th_out_q <= th_out_d;
    end
  end
  assign set_stb = set_stb_q;
  assign set_addr = set_addr_q;
  assign set_data = set_data_q;
  assign busy = busy_q;
  assign done = done_q;
  assign th_out = th_out_q;
endmodule

// File: tb/tb_ed_threshold_writer.sv
// tb_ed_threshold_writer: directed checks of averaging, scaling, settings-bus write sequence and reset/start handling
module tb_ed_threshold_writer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [31:0] xk_sq_m = '0;
  logic dv_sq_m = 1'b0;
  logic start = 1'b0;
  logic [7:0] scale_q4 = '0;
  logic [9:0] window_size_in = '0;
  logic set_stb;
  logic [7:0] set_addr;
  logic [31:0] set_data;
  logic busy, done;
  logic [31:0] th_out;
  int errs = 0;
  int checks = 0;
  ed_threshold_writer #(.TH_ADDR(1), .WS_ADDR(3), .LOG2_AVG(4)) dut (
    .clock(clock), .reset(reset), .xk_sq_m(xk_sq_m), .dv_sq_m(dv_sq_m),
    .start(start), .scale_q4(scale_q4), .window_size_in(window_size_in),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .busy(busy), .done(done), .th_out(th_out)
  );
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, " stb"}, 32'(set_stb), 32'd0);
    chk({tag, " addr"}, 32'(set_addr), 32'd0);
    chk({tag, " data"}, set_data, 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " th_out"}, th_out, 32'd0);
  endtask
  task automatic start_run(input logic [7:0] sc, input logic [9:0] ws);
    start = 1'b1;
    scale_q4 = sc;
    window_size_in = ws;
    tick;
    start = 1'b0;
    chk("busy after start", 32'(busy), 32'd1);
  endtask
  task automatic feed(input int n, input logic [31:0] lvl, input bit gappy, input int poke_at);
    for (int i = 0; i < n; i++) begin
      if (gappy) begin
        dv_sq_m = 1'b0;
        xk_sq_m = 32'hDEAD_BEEF;
        tick;
      end
      xk_sq_m = gappy ? ((i % 2 == 1) ? 32'd2 : 32'd1) : lvl;
      dv_sq_m = 1'b1;
      start = (i == poke_at);
      tick;
      start = 1'b0;
    end
    dv_sq_m = 1'b0;
  endtask
  task automatic finish_run(input logic [31:0] exp_th, input logic [9:0] exp_ws, input bit poke);
    dv_sq_m = 1'b1;
    xk_sq_m = 32'd7777;
    tick;
    chk("E1 stb", 32'(set_stb), 32'd0);
    tick;
    chk("E2 stb", 32'(set_stb), 32'd0);
    start = poke;
    tick;
    start = 1'b0;
    chk("E3 stb", 32'(set_stb), 32'd1);
    chk("E3 addr", 32'(set_addr), 32'd1);
    chk("E3 data", set_data, exp_th);
    chk("E3 th_out", th_out, exp_th);
    tick;
    chk("E4 stb", 32'(set_stb), 32'd0);
    chk("E4 addr hold", 32'(set_addr), 32'd1);
    tick;
    chk("E5 stb", 32'(set_stb), 32'd1);
    chk("E5 addr", 32'(set_addr), 32'd3);
    chk("E5 data", set_data, {22'b0, exp_ws});
    chk("E5 done", 32'(done), 32'd0);
    tick;
    chk("E6 stb", 32'(set_stb), 32'd0);
    chk("E6 done", 32'(done), 32'd1);
    chk("E6 busy", 32'(busy), 32'd1);
    start = poke;
    tick;
    start = 1'b0;
    dv_sq_m = 1'b0;
    chk("E7 done", 32'(done), 32'd0);
    chk("E7 busy", 32'(busy), 32'd0);
    chk("E7 th_out", th_out, exp_th);
  endtask
  initial begin
    tick;
    tick;
    chk_idle_outputs("reset");
    reset = 1'b0;
    tick;
    chk_idle_outputs("post reset");
    start_run(8'h30, 10'd64);
    feed(16, 32'd100, 1'b0, -1);
    finish_run(32'd300, 10'd64, 1'b0);
    start_run(8'h20, 10'd64);
    feed(16, 32'd50, 1'b0, -1);
    finish_run(32'd100, 10'd64, 1'b0);
    start_run(8'h18, 10'd64);
    feed(16, 32'd0, 1'b1, -1);
    finish_run(32'd1, 10'd64, 1'b0);
    start_run(8'hFF, 10'd0);
    feed(16, 32'hFFFF_FFFF, 1'b0, -1);
    finish_run(32'hFFFF_FFFF, 10'd1, 1'b0);
    start_run(8'h30, 10'd64);
    feed(16, 32'd100, 1'b0, 5);
    finish_run(32'd300, 10'd64, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("no rerun busy", 32'(busy), 32'd0);
      chk("no rerun stb", 32'(set_stb), 32'd0);
    end
    start_run(8'h30, 10'd64);
    feed(5, 32'd1000, 1'b0, -1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk_idle_outputs("reset in accum");
    feed(20, 32'd1000, 1'b0, -1);
    chk("after abort busy", 32'(busy), 32'd0);
    chk("after abort stb", 32'(set_stb), 32'd0);
    start_run(8'h30, 10'd64);
    feed(16, 32'd100, 1'b0, -1);
    finish_run(32'd300, 10'd64, 1'b0);
    start_run(8'h30, 10'd64);
    feed(16, 32'd100, 1'b0, -1);
    tick;
    tick;
    tick;
    chk("pre-reset stb", 32'(set_stb), 32'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk_idle_outputs("reset at strobe");
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("no ws write stb", 32'(set_stb), 32'd0);
    end
    start_run(8'h20, 10'd32);
    feed(16, 32'd50, 1'b0, -1);
    finish_run(32'd100, 10'd32, 1'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ed_threshold_writer.md
# ed_threshold_writer

Adaptive threshold programmer for the energy detector. It measures the noise floor by averaging a run of squared-magnitude samples (`xk_sq_m`/`dv_sq_m`) and scales the mean by a host-supplied factor. It then acts as a settings-bus master, writing the threshold register (address 1) and the window-size register (address 3) of the energy detection block through `set_stb`/`set_addr`/`set_data`. It sits between the FFT magnitude-squared stage and the settings-bus mux in front of the detector.

## Interface
- `TH_ADDR`, default 1: settings address of the threshold register.
- `WS_ADDR`, default 3: settings address of the window-size register.
- `LOG2_AVG`, default 10: the noise-floor estimate averages 2^LOG2_AVG valid samples. Legal range 1..12.
- `clock` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `xk_sq_m` input, 32 bits: unsigned squared-magnitude sample.
- `dv_sq_m` input, 1 bit: sample valid; `xk_sq_m` is accepted on a clock edge where this is high.
- `start` input, 1 bit: one-cycle request to begin a calibration run.
- `scale_q4` input, 8 bits: unsigned Q4.4 multiplier. 0x10 = 1.0, 0xFF = 15.9375.
- `window_size_in` input, 10 bits: window size to program into `WS_ADDR`.
- `set_stb` output, 1 bit: settings write strobe.
- `set_addr` output, 8 bits: settings address.
- `set_data` output, 32 bits: settings write data.
- `busy` output, 1 bit: calibration run in progress.
- `done` output, 1 bit: one-cycle pulse when the run completes.
- `th_out` output, 32 bits: last threshold written. Holds its value until the next run.

## Operation
- FSM states: IDLE, ACCUM, MEAN, SCALE, WR_TH, GAP, WR_WS, DONE.
- **IDLE.** When `start`=1, clear the accumulator and sample counter, set `busy`=1, and go to ACCUM. `start` is ignored in every other state.
- **ACCUM.** On each edge with `dv_sq_m`=1:
  - add `xk_sq_m` to the accumulator, which is (32+LOG2_AVG) bits wide and cannot overflow;
  - increment the counter.
  - Cycles with `dv_sq_m`=0 are skipped.
  - When the sample that completes the count (2^LOG2_AVG-th) is accepted, go to MEAN.
- **MEAN.** `mean = acc >> LOG2_AVG`. Truncating divide, 32-bit result.
- **SCALE.** `prod = mean * scale_q4`, 40 bits. Then `th = prod >> 4`, truncated. If `th` exceeds 32'hFFFFFFFF, saturate to 32'hFFFFFFFF. `scale_q4`=0 gives `th`=0, which is legal.
- **WR_TH.** Drive `set_stb`=1, `set_addr`=`TH_ADDR`, `set_data`=`th`. Update `th_out`=`th`.
- **GAP.** `set_stb`=0 for exactly one cycle.
- **WR_WS.** Drive `set_stb`=1, `set_addr`=`WS_ADDR`, `set_data`={22'b0, ws}.
  - ws = `window_size_in`, or 1 if `window_size_in`=0 (a zero window is never written).
  - `window_size_in` is sampled in this state.
- **DONE.** Pulse `done`=1, then return to IDLE and drop `busy`.
- `set_addr` and `set_data` hold their last written values whenever `set_stb`=0. Receivers must qualify on `set_stb` only.
- `scale_q4` is sampled in SCALE. Changes to it during ACCUM have no effect until then.

## Timing
- All outputs are registered.
- Reset values: `set_stb`=0, `set_addr`=0, `set_data`=0, `busy`=0, `done`=0, `th_out`=0. The FSM resets to IDLE and the accumulator and counter clear.
- Edge naming:
  - S: the edge on which `start`=1 is seen in IDLE. `busy`=1 from S.
  - E0: the edge that accepts the final sample.
  - Minimum S-to-E0 is 2^LOG2_AVG edges, counting S+1 as the first possible acceptance.
- Cycle sequence after E0:
  - E1 (MEAN) and E2 (SCALE) are compute edges.
  - After E3: `set_stb`=1 with the threshold; `th_out` updates.
  - After E4: `set_stb`=0.
  - After E5: `set_stb`=1 with the window size.
  - After E6: `set_stb`=0, `done`=1.
  - After E7: `done`=0, `busy`=0.
- Each strobe is exactly one cycle. The two writes are always separated by one idle cycle, so `setting_reg` sees two distinct strobes.
- `start` asserted on the same edge that `busy` falls (E7) is ignored. The earliest new run starts at E8.
- Reset mid-run, in any state:
  - abort on the next edge and return to IDLE;
  - no further strobes are issued;
  - a strobe in progress is deasserted;
  - `th_out` returns to 0.
- `dv_sq_m` seen in states other than ACCUM is ignored.

## Test plan
- **Nominal run.** LOG2_AVG=4, 16 samples of 100 with `dv_sq_m` continuous, `scale_q4`=0x30, `window_size_in`=64.
  - Required: strobe addr 1 / data 300, one idle cycle, strobe addr 3 / data 64.
  - `done` pulses 6 cycles after E0 (at E6); `th_out`=300; `busy` returns to 0.
- **Truncation and gappy valid.** LOG2_AVG=4, samples alternating 1,2 with `dv_sq_m` toggling every cycle, `scale_q4`=0x18.
  - Required: sum 24, mean 1, threshold write data 1.
  - Accumulation takes 32 cycles.
- **Saturation and zero window.** All samples 32'hFFFFFFFF, `scale_q4`=0xFF, `window_size_in`=0.
  - Required: threshold data 32'hFFFFFFFF, window-size data 1.
- **Start while busy.** Pulse `start` during ACCUM, again during WR_TH, and again on the edge `busy` falls.
  - Required: exactly one pair of writes, one `done`, and no new run.
- **Reset mid-run.** Assert `reset` for one cycle in ACCUM. On a second run, assert it on the cycle `set_stb`=1 for the threshold.
  - Required: `set_stb` is 0 on the next cycle, no window-size write, all outputs at reset values.
  - A subsequent `start` produces a correct fresh average, unaffected by pre-reset samples.
- **Back-to-back runs.** Issue `start` at E8 with a different sample level (50, `scale_q4`=0x20).
  - Required: second threshold write data 100; `th_out` goes 300 → 100.
